// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR tap chain and its coefficient bank.
package fir_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_COEF_W = 2;
  localparam int DEF_TAPS   = 3;
  localparam int DEF_OUT_W  = 8;
  localparam int COEF_RST   = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x COEF_W coefficient register file with one write port and a flattened
// parallel read of every entry.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int AW     = 2
) (
  input  logic                   clock_pulse,
  input  logic                   clr_de_n,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic [COEF_W-1:0]      coef_data,
  output logic [TAPS*COEF_W-1:0] coefs
);

  logic [COEF_W-1:0] c [TAPS];

  // Addresses at or beyond TAPS are silently dropped.
  always_ff @(posedge clock_pulse or negedge clr_de_n) begin
    if (!clr_de_n) begin
      for (int k = 0; k < TAPS; k++) c[k] <= COEF_W'(COEF_RST);
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      c[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    coefs = '0;
    for (int k = 0; k < TAPS; k++) coefs[k*COEF_W +: COEF_W] = c[k];
  end

endmodule

// File: rtl/fir_tap_chain.sv
// Direct-form FIR: sample delay line, registered products, registered
// sum-and-saturate. Two register stages from accepted sample to dout.
module fir_tap_chain
  import fir_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int COEF_W = DEF_COEF_W,
  parameter  int TAPS   = DEF_TAPS,
  parameter  int OUT_W  = DEF_OUT_W,
  localparam int ACC_W  = DATA_W + COEF_W + clog2(TAPS),
  localparam int AW     = (clog2(TAPS) > 0) ? clog2(TAPS) : 1
) (
  input  logic              clock_pulse,
  input  logic              clr_de_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  dout,
  output logic              out_sat
);

  // Streaming is valid-only: a sample moves whenever in_valid is high and
  // flush is low; there is no ready, so every out_valid pulse must be taken.
  localparam int PROD_W = DATA_W + COEF_W;

  logic [TAPS*COEF_W-1:0] coefs;
  logic [DATA_W-1:0]      x      [TAPS];
  logic [DATA_W-1:0]      x_next [TAPS];
  logic [PROD_W-1:0]      p      [TAPS];
  logic                   v1;
  logic                   accept;
  logic [ACC_W-1:0]       acc;
  logic [OUT_W-1:0]       dout_next;
  logic                   sat_next;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .AW     (AW)
  ) u_coef_bank (
    .clock_pulse (clock_pulse),
    .clr_de_n    (clr_de_n),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coefs       (coefs)
  );

  assign accept = in_valid & ~flush;

  always_comb begin
    x_next[0] = din;
    for (int k = 1; k < TAPS; k++) x_next[k] = x[k-1];
  end

  always_ff @(posedge clock_pulse or negedge clr_de_n) begin
    if (!clr_de_n) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < TAPS; k++) x[k] <= x_next[k];
    end
  end

  // Products use the coefficient value before any write landing on this edge.
  always_ff @(posedge clock_pulse or negedge clr_de_n) begin
    if (!clr_de_n) begin
      for (int k = 0; k < TAPS; k++) p[k] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        for (int k = 0; k < TAPS; k++)
          p[k] <= PROD_W'(x_next[k]) * PROD_W'(coefs[k*COEF_W +: COEF_W]);
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(p[k]);
  end

  generate
    if (OUT_W >= ACC_W) begin : g_wide
      assign dout_next = OUT_W'(acc);
      assign sat_next  = 1'b0;
    end else begin : g_sat
      localparam logic [ACC_W-1:0] MAX_OUT = ACC_W'({OUT_W{1'b1}});
      assign sat_next  = (acc > MAX_OUT);
      assign dout_next = sat_next ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clock_pulse or negedge clr_de_n) begin
    if (!clr_de_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        dout    <= dout_next;
        out_sat <= sat_next;
      end
    end
  end

endmodule
